// File: rtl/dsram_arbiter.sv
// dsram_arbiter: shares the single data SRAM port between M0 (MEM-stage load/store) and M1 (secondary master).
// Latency: grant and SRAM drive are combinational in the request cycle; data_ok returns exactly RD_LAT cycles after addr_ok.
// Backpressure: the losing requester sees addr_ok=0 and holds its request; the response path has no backpressure.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   m0_req/wr/wstrb/addr/wdata     M0 request;  m0_addr_ok (accepted), m0_data_ok + m0_rdata (response)
//   m1_*                           same as M0, for M1
//   data_sram_en/we/addr/wdata     SRAM command, driven from the winner
//   data_sram_rdata                SRAM read data, RD_LAT cycles after en
module dsram_arbiter #(
  parameter int RD_LAT       = 1,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic              w_m1_pref;     // 1: M1 takes the next conflict
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_rsp_vld;
  logic              w_rsp_id;

  logic              r_rr_last;     // winner of the previous conflict (0 = M0, 1 = M1)
  logic [3:0]        r_starve_cnt;  // consecutive cycles M1 has been denied
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_id;

  // Conflict resolution. Both trackers are kept running in either mode;
  // only the one selected by PRIO_MODE steers the grant.
  always_comb begin
    if (PRIO_MODE == 0) begin
      w_m1_pref = ~r_rr_last;
    end else begin
      w_m1_pref = (r_starve_cnt == LP_LIMIT);
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  assign w_gnt0 = ~reset & m0_req & ~(m1_req &  w_m1_pref);
  assign w_gnt1 = ~reset & m1_req & ~(m0_req & ~w_m1_pref);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last    <= 1'b1;         // pretend M1 won last, so M0 gets the first conflict
      r_starve_cnt <= '0;
      r_tag_vld    <= '0;
      r_tag_id     <= '0;
    end else begin
      if (m0_req && m1_req) begin
        r_rr_last <= w_gnt1;
      end

      if (m1_req && !w_gnt1) begin
        if (r_starve_cnt != LP_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else begin
        r_starve_cnt <= '0;
      end

      // Tag pipeline: one slot per cycle of SRAM latency, shifts unconditionally.
      r_tag_vld[0] <= w_gnt0 | w_gnt1;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign m0_addr_ok   = w_gnt0;
  assign m1_addr_ok   = w_gnt1;
  assign data_sram_en = w_gnt0 | w_gnt1;

  always_comb begin
    data_sram_we    = 4'b0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (w_gnt1) begin
      data_sram_we    = m1_wr ? m1_wstrb : 4'b0;
      data_sram_addr  = m1_addr;
      data_sram_wdata = m1_wdata;
    end else if (w_gnt0) begin
      data_sram_we    = m0_wr ? m0_wstrb : 4'b0;
      data_sram_addr  = m0_addr;
      data_sram_wdata = m0_wdata;
    end
  end

  // Response routing from the oldest tag slot.
  assign w_rsp_vld = r_tag_vld[RD_LAT-1] & ~reset;
  assign w_rsp_id  = r_tag_id[RD_LAT-1];

  assign m0_data_ok = w_rsp_vld & ~w_rsp_id;
  assign m1_data_ok = w_rsp_vld &  w_rsp_id;
  assign m0_rdata   = m0_data_ok ? data_sram_rdata : 32'h0;
  assign m1_rdata   = m1_data_ok ? data_sram_rdata : 32'h0;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: two instances (RD_LAT=1 round-robin, RD_LAT=3 fixed priority),
// each with its own SRAM model, driven from per-requester transaction queues.
module tb_dsram_arbiter;

  localparam int STARVE = 4;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        m0_req[2], m0_wr[2], m0_addr_ok[2], m0_data_ok[2];
  logic [3:0]  m0_wstrb[2];
  logic [31:0] m0_addr[2], m0_wdata[2], m0_rdata[2];
  logic        m1_req[2], m1_wr[2], m1_addr_ok[2], m1_data_ok[2];
  logic [3:0]  m1_wstrb[2];
  logic [31:0] m1_addr[2], m1_wdata[2], m1_rdata[2];
  logic        sram_en[2];
  logic [3:0]  sram_we[2];
  logic [31:0] sram_addr[2], sram_wdata[2], sram_rdata[2];

  dsram_arbiter #(.RD_LAT(1), .PRIO_MODE(0), .STARVE_LIMIT(STARVE)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req[0]), .m0_wr(m0_wr[0]), .m0_wstrb(m0_wstrb[0]), .m0_addr(m0_addr[0]),
    .m0_wdata(m0_wdata[0]), .m0_addr_ok(m0_addr_ok[0]), .m0_data_ok(m0_data_ok[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_wr(m1_wr[0]), .m1_wstrb(m1_wstrb[0]), .m1_addr(m1_addr[0]),
    .m1_wdata(m1_wdata[0]), .m1_addr_ok(m1_addr_ok[0]), .m1_data_ok(m1_data_ok[0]), .m1_rdata(m1_rdata[0]),
    .data_sram_en(sram_en[0]), .data_sram_we(sram_we[0]), .data_sram_addr(sram_addr[0]),
    .data_sram_wdata(sram_wdata[0]), .data_sram_rdata(sram_rdata[0])
  );

  dsram_arbiter #(.RD_LAT(3), .PRIO_MODE(1), .STARVE_LIMIT(STARVE)) u_pr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req[1]), .m0_wr(m0_wr[1]), .m0_wstrb(m0_wstrb[1]), .m0_addr(m0_addr[1]),
    .m0_wdata(m0_wdata[1]), .m0_addr_ok(m0_addr_ok[1]), .m0_data_ok(m0_data_ok[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_wr(m1_wr[1]), .m1_wstrb(m1_wstrb[1]), .m1_addr(m1_addr[1]),
    .m1_wdata(m1_wdata[1]), .m1_addr_ok(m1_addr_ok[1]), .m1_data_ok(m1_data_ok[1]), .m1_rdata(m1_rdata[1]),
    .data_sram_en(sram_en[1]), .data_sram_we(sram_we[1]), .data_sram_addr(sram_addr[1]),
    .data_sram_wdata(sram_wdata[1]), .data_sram_rdata(sram_rdata[1])
  );

  always #5 clk = ~clk;

  // SRAM models: 256 words each, read data appears RD_LAT cycles after en.
  logic [31:0] mem [2][256];
  logic [31:0] rp  [2][4];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) rp[k][j] <= rp[k][j-1];
      rp[k][0] <= sram_en[k] ? mem[k][sram_addr[k][9:2]] : 32'h0;
      if (sram_en[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[k][b]) mem[k][sram_addr[k][9:2]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
        end
      end
    end
  end

  assign sram_rdata[0] = rp[0][0];
  assign sram_rdata[1] = rp[1][2];

  // Reference model state.
  txn_t        rq [4][$];    // pending requests, index = dut*2 + requester
  rsp_t        eq [2][$];    // expected responses in issue order
  logic [31:0] mm [2][256];  // expected SRAM contents
  int          last_win[2];  // requester that won the last conflict
  int          denied[2];    // consecutive M1 denials
  int          hist[2][$];   // observed grant per cycle (0, 1, 2 = none)
  int          rhist[2][$];  // observed responder per cycle
  int          cyc;
  int          n_pass = 0;
  int          n_total = 0;
  int          exp_rr[8];
  int          exp_pr[12];
  int          exp_b2b[7];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_val(input int k, input int i);
    if (i == 32'h40) return 32'hDEADBEEF;
    return 32'hC0DE0000 | (k << 12) | i;
  endfunction

  function automatic txn_t mk(input logic wr, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = wr; t.wstrb = s; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return mk(1'($urandom_range(0, 1)), 4'($urandom), {22'h0, w, 2'b00}, $urandom);
  endfunction

  function automatic string tg(input int k, input string name);
    return $sformatf("dut%0d_cyc%0d_%s", k, cyc, name);
  endfunction

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (rq[i].size() != 0) b = 1'b1;
    for (int k = 0; k < 2; k++) if (eq[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_resp();
    for (int k = 0; k < 2; k++) begin
      int   id;
      logic wr;
      logic [31:0] d;
      id = 2; wr = 1'b0; d = 32'h0;
      if (eq[k].size() != 0 && eq[k][0].due == cyc) begin
        id = eq[k][0].id; wr = eq[k][0].wr; d = eq[k][0].data;
        void'(eq[k].pop_front());
      end
      chk(tg(k, "m0_data_ok"), m0_data_ok[k], id == 0);
      chk(tg(k, "m1_data_ok"), m1_data_ok[k], id == 1);
      if (id != 0) chk(tg(k, "m0_rdata_idle"), m0_rdata[k], 32'h0);
      else if (!wr) chk(tg(k, "m0_rdata"), m0_rdata[k], d);
      if (id != 1) chk(tg(k, "m1_rdata_idle"), m1_rdata[k], 32'h0);
      else if (!wr) chk(tg(k, "m1_rdata"), m1_rdata[k], d);
      rhist[k].push_back(m0_data_ok[k] ? 0 : (m1_data_ok[k] ? 1 : 2));
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 2; k++) begin
      txn_t t0, t1;
      t0 = mk(1'b0, 4'h0, 32'h0, 32'h0);
      t1 = t0;
      if (rq[2*k].size() != 0)   t0 = rq[2*k][0];
      if (rq[2*k+1].size() != 0) t1 = rq[2*k+1][0];
      m0_req[k] = rq[2*k].size() != 0;
      m0_wr[k] = t0.wr; m0_wstrb[k] = t0.wstrb; m0_addr[k] = t0.addr; m0_wdata[k] = t0.wdata;
      m1_req[k] = rq[2*k+1].size() != 0;
      m1_wr[k] = t1.wr; m1_wstrb[k] = t1.wstrb; m1_addr[k] = t1.addr; m1_wdata[k] = t1.wdata;
    end
  endtask

  task automatic check_grant();
    for (int k = 0; k < 2; k++) begin
      bit   r0, r1;
      int   win, wi;
      txn_t t;
      rsp_t r;
      r0 = rq[2*k].size() != 0;
      r1 = rq[2*k+1].size() != 0;
      if (r0 && r1) begin
        if (k == 0) win = (last_win[k] == 0) ? 1 : 0;
        else        win = (denied[k] >= STARVE) ? 1 : 0;
        last_win[k] = win;
      end else if (r0) win = 0;
      else if (r1) win = 1;
      else win = 2;
      if (k == 1) denied[k] = (r1 && win != 1) ? ((denied[k] + 1 > STARVE) ? STARVE : denied[k] + 1) : 0;

      chk(tg(k, "m0_addr_ok"), m0_addr_ok[k], win == 0);
      chk(tg(k, "m1_addr_ok"), m1_addr_ok[k], win == 1);
      chk(tg(k, "sram_en"), sram_en[k], win != 2);
      hist[k].push_back(m0_addr_ok[k] ? 0 : (m1_addr_ok[k] ? 1 : 2));
      if (win != 2) begin
        t = rq[2*k+win].pop_front();
        chk(tg(k, "sram_addr"), sram_addr[k], t.addr);
        chk(tg(k, "sram_wdata"), sram_wdata[k], t.wdata);
        chk(tg(k, "sram_we"), sram_we[k], t.wr ? t.wstrb : 4'h0);
        wi = int'(t.addr[9:2]);
        r.id = win; r.wr = t.wr; r.data = mm[k][wi]; r.due = cyc + lat_of(k);
        if (t.wr) for (int b = 0; b < 4; b++) if (t.wstrb[b]) mm[k][wi][8*b +: 8] = t.wdata[8*b +: 8];
        eq[k].push_back(r);
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    check_resp();
    drive_inputs();
    #1;
    check_grant();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (busy() && n < bound) begin
      cycle();
      n++;
    end
    chk($sformatf("cyc%0d_drain_idle", cyc), busy(), 1'b0);
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk(tg(k, "rst_m0_addr_ok"), m0_addr_ok[k], 1'b0);
      chk(tg(k, "rst_m1_addr_ok"), m1_addr_ok[k], 1'b0);
      chk(tg(k, "rst_m0_data_ok"), m0_data_ok[k], 1'b0);
      chk(tg(k, "rst_m1_data_ok"), m1_data_ok[k], 1'b0);
      chk(tg(k, "rst_sram_en"), sram_en[k], 1'b0);
      chk(tg(k, "rst_sram_we"), sram_we[k], 4'h0);
      chk(tg(k, "rst_m0_rdata"), m0_rdata[k], 32'h0);
      chk(tg(k, "rst_m1_rdata"), m1_rdata[k], 32'h0);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 2; k++) begin
      hist[k].delete();
      rhist[k].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_rr  = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp_pr  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    exp_b2b = '{2, 2, 2, 0, 1, 1, 0};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) begin
        mem[k][i] <= init_val(k, i);
        mm[k][i]  = init_val(k, i);
      end
      last_win[k] = 1;
      denied[k]   = 0;
      m0_req[k] = 1'b1; m0_wr[k] = 1'b1; m0_wstrb[k] = 4'hF; m0_addr[k] = 32'h0; m0_wdata[k] = 32'h0;
      m1_req[k] = 1'b1; m1_wr[k] = 1'b1; m1_wstrb[k] = 4'hF; m1_addr[k] = 32'h4; m1_wdata[k] = 32'h0;
    end
    cyc = 0;

    // Reset state with both requesters asserting.
    reset = 1'b1;
    #2;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;

    // Single M0 read of 0x100 (holds 0xDEADBEEF).
    rq[0].push_back(mk(1'b0, 4'h0, 32'h100, 32'h0));
    rq[2].push_back(mk(1'b0, 4'h0, 32'h100, 32'h0));
    cycle();
    chk("single_rd_m0_data_ok", m0_data_ok[0], 1'b1);
    chk("single_rd_m0_rdata", m0_rdata[0], 32'hDEADBEEF);
    chk("single_rd_m1_data_ok", m1_data_ok[0], 1'b0);
    drain(10);

    // Continuous conflict: round-robin alternation and the starvation guard.
    clear_hist();
    for (int i = 0; i < 4; i++) begin
      rq[0].push_back(mk(1'b0, 4'h0, 32'(16 * i), 32'h0));
      rq[1].push_back(mk(1'b1, 4'b0011, 32'(16 * i + 8), 32'hA5A50000 + 32'(i)));
    end
    for (int i = 0; i < 12; i++) begin
      rq[2].push_back(mk(1'b0, 4'h0, 32'(4 * i), 32'h0));
      rq[3].push_back(mk(1'b1, 4'b0011, 32'(4 * i + 64), 32'h5A5A0000 + 32'(i)));
    end
    repeat (12) cycle();
    for (int i = 0; i < 8; i++) chk($sformatf("rr_grant_%0d", i), hist[0][i], exp_rr[i]);
    for (int i = 0; i < 12; i++) chk($sformatf("prio_grant_%0d", i), hist[1][i], exp_pr[i]);
    drain(20);

    // RD_LAT=3 back-to-back accepts M0, M1, M1, M0.
    clear_hist();
    rq[2].push_back(mk(1'b0, 4'h0, 32'h10, 32'h0)); cycle();
    rq[3].push_back(mk(1'b0, 4'h0, 32'h14, 32'h0)); cycle();
    rq[3].push_back(mk(1'b0, 4'h0, 32'h18, 32'h0)); cycle();
    rq[2].push_back(mk(1'b0, 4'h0, 32'h1C, 32'h0)); cycle();
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_grant_%0d", i), hist[1][i], exp_b2b[i + 3]);
    for (int i = 0; i < 7; i++) chk($sformatf("b2b_resp_%0d", i), rhist[1][i], exp_b2b[i]);
    drain(10);

    // Reset one cycle after an accept, with M1 left waiting.
    for (int k = 0; k < 2; k++) begin
      rq[2*k].push_back(mk(1'b0, 4'h0, 32'h20, 32'h0));
      rq[2*k+1].push_back(mk(1'b0, 4'h0, 32'h24, 32'h0));
    end
    cycle();
    check_resp();
    for (int k = 0; k < 2; k++) rq[2*k].push_back(mk(1'b0, 4'h0, 32'h28, 32'h0));
    drive_inputs();
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (2) begin
      @(negedge clk);
      cyc++;
      chk_reset_outputs();
    end
    for (int k = 0; k < 2; k++) begin
      eq[k].delete();
      last_win[k] = 1;
      denied[k]   = 0;
    end
    reset = 1'b0;
    clear_hist();
    cycle();
    chk("post_reset_rr_first", hist[0][0], 0);
    chk("post_reset_pr_first", hist[1][0], 0);
    drain(20);

    // Zero-strobe M1 write to 0x200 leaves memory untouched.
    rq[1].push_back(mk(1'b1, 4'h0, 32'h200, 32'hFFFFFFFF));
    rq[3].push_back(mk(1'b1, 4'h0, 32'h200, 32'hFFFFFFFF));
    drain(10);
    repeat (2) cycle();
    chk("zero_strobe_mem_dut0", mem[0][128], init_val(0, 128));
    chk("zero_strobe_mem_dut1", mem[1][128], init_val(1, 128));

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq[i].size() < 3 && $urandom_range(0, 99) < 45) rq[i].push_back(rand_txn());
      end
      cycle();
    end
    drain(80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
- Shares the single data SRAM port between two requesters: M0 (MEM-stage load/store path) and M1 (secondary master, e.g. debug/DMA engine).
- Accepts at most one access per cycle and drives the SRAM combinationally from the winner.
- Tracks in-flight accesses in a RD_LAT-deep tag pipeline so each SRAM response returns to the requester that issued it.
- Sits between the pipeline/secondary master and data_sram_* at the CPU top level.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles from en to valid rdata; legal 1..4.
- PRIO_MODE, 0, 0 = round-robin on conflict; 1 = M0 fixed priority with M1 starvation guard.
- STARVE_LIMIT, 4, in PRIO_MODE=1, consecutive M1 denials after which M1 wins the next conflict; legal 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- m0_req  in  1  M0 access request.
- m0_wr  in  1  1 = write, 0 = read.
- m0_wstrb  in  4  byte write strobes (ignored for reads).
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_addr_ok  out  1  request accepted this cycle.
- m0_data_ok  out  1  response for an earlier accepted M0 access.
- m0_rdata  out  32  read data, valid with m0_data_ok.
- m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata  same as M0, for M1.
- data_sram_en  out  1  SRAM enable.
- data_sram_we  out  4  SRAM byte write enables.
- data_sram_addr  out  32  SRAM address.
- data_sram_wdata  out  32  SRAM write data.
- data_sram_rdata  in  32  SRAM read data, RD_LAT cycles after en.

Behaviour:
- Reset (async assert, sync release):
  - Clears the tag pipeline, rr_last (reset value = M1, so M0 wins the first conflict) and starve_cnt.
  - While reset is high: all addr_ok, data_ok and data_sram_en are 0; data_sram_we = 0; rdata outputs = 0.
- Grant is combinational, same cycle as the request:
  - One requester active: it wins.
  - Both active: the winner is chosen by PRIO_MODE.
- Acceptance:
  - The winner's addr_ok = 1 in the same cycle.
  - data_sram_en = 1; addr and wdata come from the winner.
  - data_sram_we = wstrb if wr, else 4'b0.
  - The loser's addr_ok = 0 and it must hold its request stable; no request is ever dropped.
- PRIO_MODE=0:
  - On a conflict the winner is the requester that did not win the previous conflict.
  - rr_last updates only on conflict cycles.
- PRIO_MODE=1:
  - M0 wins conflicts unless starve_cnt == STARVE_LIMIT, in which case M1 wins.
  - starve_cnt increments on each cycle M1 is denied.
  - starve_cnt clears when M1 is granted or m1_req is low.
  - starve_cnt saturates at STARVE_LIMIT.
- Tag pipeline:
  - Each acceptance pushes {valid=1, id} into stage 0; non-acceptance pushes valid=0.
  - The pipeline shifts every cycle; there is no backpressure.
  - At stage RD_LAT-1 output: if valid, data_ok of requester id is 1 for exactly one cycle, and that requester's rdata = data_sram_rdata.
  - The other requester's rdata = 0.
  - Writes also return data_ok; rdata for writes is don't-care and driven from data_sram_rdata.
- Latency: data_ok rises exactly RD_LAT cycles after the addr_ok cycle. Responses are in issue order; per-requester ordering is preserved.
- Throughput: one acceptance per cycle sustained. Back-to-back accesses from the same or alternating requesters are allowed.
- A zero-strobe write is accepted normally: en=1, we=0, and it still produces a data_ok.
- Reset mid-operation: all in-flight tags are discarded and no data_ok is produced for them after reset.
- A request and a data_ok for the same requester may occur in the same cycle; they are independent.

Test Plan:
- Single M0 read (RD_LAT=1, addr 0x100, SRAM holds 0xDEADBEEF) -> m0_addr_ok in cycle T, data_sram_en=1 and addr=0x100 in T, m0_data_ok=1 with rdata=0xDEADBEEF in T+1, m1_data_ok stays 0.
- PRIO_MODE=0, both requesting continuously (M0 reads, M1 writes wstrb=4'b0011) -> grants alternate M0, M1, M0, M1; M1 cycles show data_sram_we=4'b0011; each data_ok lands on the correct port one cycle later.
- PRIO_MODE=1, STARVE_LIMIT=4, both requesting for 12 cycles -> grant order M0 x4, M1, M0 x4, M1, M0 x2; starve_cnt is 0 after each M1 grant.
- RD_LAT=3, four back-to-back accepts (M0, M1, M1, M0) -> data_ok pattern M0, M1, M1, M0 in cycles T+3..T+6, with rdata routed to the matching ports.
- reset asserted asynchronously one cycle after an RD_LAT=2 accept -> no data_ok after reset; all outputs 0 during reset; after release the first conflict is granted to M0.
- Zero-strobe M1 write (wstrb=0, addr 0x200) -> m1_addr_ok=1, data_sram_en=1, data_sram_we=0, m1_data_ok after RD_LAT cycles; SRAM contents at 0x200 unchanged.
